// File: rtl/imem_server.sv
// Instruction-memory server for the RiSC-16 core.
// Loads a big-endian byte-serial program image, holds the core in reset
// while loading, then serves zero-latency fetches (instruction = mem[pc]).
module imem_server #(
   parameter int p_IMEM_SIZE = 1024,
   parameter int p_ADDR_LEN  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [7:0]  load_byte,
   input  logic        load_last,
   input  logic        reload,
   input  logic [15:0] pc,
   output logic [15:0] instruction,
   output logic        core_rst,
   output logic [15:0] word_count,
   output logic        overflow
);

   // Memory index width follows the array depth; the write pointer keeps one
   // extra bit so it can sit at p_IMEM_SIZE once the memory is full.
   localparam int                  IDX_W    = (p_IMEM_SIZE > 1) ? $clog2(p_IMEM_SIZE) : 1;
   localparam logic [p_ADDR_LEN:0] SIZE_PTR = p_IMEM_SIZE[p_ADDR_LEN:0];
   localparam logic [p_ADDR_LEN:0] PTR_ONE  = 1;
   localparam logic [16:0]         SIZE_PC  = p_IMEM_SIZE[16:0];

   typedef enum logic {S_LOAD, S_RUN} state_e;

   state_e              state_q,    state_d;
   logic [p_ADDR_LEN:0] wr_ptr_q,   wr_ptr_d;
   logic                phase_q,    phase_d;
   logic [7:0]          hi_byte_q,  hi_byte_d;
   logic                overflow_q, overflow_d;
   logic                core_rst_q, core_rst_d;

   logic                xfer;
   logic                word_wr;
   logic                mem_we;
   logic [15:0]         mem_wdata;
   logic [IDX_W-1:0]    mem_widx;

   logic [15:0]         mem [p_IMEM_SIZE];

   // Next-state: byte assembly, word write / overflow, LOAD <-> RUN transitions
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      phase_d    = phase_q;
      hi_byte_d  = hi_byte_q;
      overflow_d = overflow_q;
      xfer       = load_valid && (state_q == S_LOAD);
      word_wr    = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = {hi_byte_q, load_byte};
      mem_widx   = wr_ptr_q[IDX_W-1:0];

      case (state_q)
         S_LOAD: begin
            if (xfer) begin
               if (!phase_q) begin
                  hi_byte_d = load_byte;
                  phase_d   = 1'b1;
                  // odd image: the lone final byte becomes the high half of a padded word
                  if (load_last) begin
                     word_wr   = 1'b1;
                     mem_wdata = {load_byte, 8'h00};
                     phase_d   = 1'b0;
                  end
               end else begin
                  word_wr = 1'b1;
                  phase_d = 1'b0;
               end
               if (load_last) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (reload) begin
               state_d    = S_LOAD;
               wr_ptr_d   = '0;
               phase_d    = 1'b0;
               overflow_d = 1'b0;
            end
         end
         default: state_d = S_LOAD;
      endcase

      // words past the end are dropped; the pointer (and word count) saturates
      if (word_wr) begin
         if (wr_ptr_q < SIZE_PTR) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            overflow_d = 1'b1;
         end
      end

      // core reset rises with the reload edge but falls one edge after RUN is entered
      core_rst_d = (state_q == S_LOAD) || (state_d == S_LOAD);
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_LOAD;
         wr_ptr_q   <= '0;
         phase_q    <= 1'b0;
         hi_byte_q  <= 8'h00;
         overflow_q <= 1'b0;
         core_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         phase_q    <= phase_d;
         hi_byte_q  <= hi_byte_d;
         overflow_q <= overflow_d;
         core_rst_q <= core_rst_d;
      end
   end

   // Program memory write port; contents survive reset and reload
   always_ff @(posedge clk) begin
      if (mem_we && rst) mem[mem_widx] <= mem_wdata;
   end

   // Fetch port: zero latency, NOP outside the array or while loading
   always_comb begin
      instruction = 16'h0000;
      if ((state_q == S_RUN) && ({1'b0, pc} < SIZE_PC)) instruction = mem[pc[IDX_W-1:0]];
   end

   assign load_ready = (state_q == S_LOAD);
   assign core_rst   = core_rst_q;
   assign overflow   = overflow_q;
   assign word_count = 16'(wr_ptr_q);

endmodule

// File: tb/tb_imem_server.sv
// Randomised self-checking bench for imem_server: fetches are scoreboarded
// against a word-level model of the loaded image.
module tb_imem_server;
   localparam int SIZE = 12;
   localparam int AW   = 4;

   typedef logic [7:0]  bq_t[$];
   typedef logic [15:0] wq_t[$];
   typedef struct {
      logic [15:0] pc;
      logic [15:0] exp;
      bit          dc;
   } fetch_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_last = 1'b0;
   logic        reload = 1'b0;
   logic [7:0]  load_byte = 8'h00;
   logic [15:0] pc = 16'h0000;
   logic        load_ready, core_rst, overflow;
   logic [15:0] instruction, word_count;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_t      sbq[$];
   logic [15:0] model_mem [SIZE];
   bit          model_wr  [SIZE];
   int          model_wc  = 0;
   bit          model_ovf = 1'b0;

   imem_server #(.p_IMEM_SIZE(SIZE), .p_ADDR_LEN(AW)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_byte(load_byte), .load_last(load_last), .reload(reload), .pc(pc),
      .instruction(instruction), .core_rst(core_rst), .word_count(word_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every cycle the core is out of reset it consumes one fetch
   always @(negedge clk) begin
      fetch_t f;
      if (rst === 1'b1 && core_rst === 1'b0) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL fetch_unexpected: core running with pc=%h instr=%h, nothing expected", pc, instruction);
         end else begin
            f = sbq.pop_front();
            if (!f.dc) check($sformatf("fetch pc=%h", f.pc), {16'h0, instruction}, {16'h0, f.exp});
         end
      end
   end

   // Model of an image load: big-endian word pairs, odd tail padded, excess dropped
   task automatic model_load(input bq_t b);
      int nw;
      logic [15:0] w;
      nw = (b.size() + 1) / 2;
      for (int i = 0; i < nw; i++) begin
         w = {b[2*i], (2*i+1 < b.size()) ? b[2*i+1] : 8'h00};
         if (model_wc < SIZE) begin
            model_mem[model_wc] = w;
            model_wr[model_wc]  = 1'b1;
            model_wc++;
         end else begin
            model_ovf = 1'b1;
         end
      end
   endtask

   function automatic fetch_t expect_fetch(input logic [15:0] p);
      fetch_t f;
      f.pc  = p;
      f.exp = 16'h0000;
      f.dc  = 1'b0;
      if (int'(p) < SIZE) begin
         f.exp = model_mem[p];
         f.dc  = !model_wr[p];
      end
      return f;
   endfunction

   function automatic logic [15:0] pick_pc();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 16'hFFFF;
      if (r == 1) return 16'(SIZE + $urandom_range(0, 3));
      if (r == 2) return 16'($urandom);
      return 16'($urandom_range(0, SIZE - 1));
   endfunction

   // Stream an image (entered and left at posedge+1, state LOAD on entry)
   task automatic send_image(input bq_t b, input int max_gap, input bit noise);
      for (int i = 0; i < b.size(); i++) begin
         repeat ($urandom_range(0, max_gap)) begin
            load_valid = 1'b0;
            reload     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            reload = 1'b0;
         end
         check("load_ready_in_load", {31'h0, load_ready}, 32'h1);
         pc = 16'($urandom);
         #1;
         check("instr_nop_in_load", {16'h0, instruction}, 32'h0);
         load_valid = 1'b1;
         load_byte  = b[i];
         load_last  = (i == b.size() - 1);
         @(posedge clk); #1;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      model_load(b);
      check("core_rst_held_after_last", {31'h0, core_rst}, 32'h1);
      check("load_ready_run", {31'h0, load_ready}, 32'h0);
      check("word_count", {16'h0, word_count}, 32'(model_wc));
      check("overflow", {31'h0, overflow}, {31'h0, model_ovf});
   endtask

   // Run the core for n cycles with optional load-port noise, then reload
   task automatic run_phase(input int n, input bit noise, input wq_t pcs);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (k == 0) check("core_rst_released", {31'h0, core_rst}, 32'h0);
         pc = (k < pcs.size()) ? pcs[k] : pick_pc();
         sbq.push_back(expect_fetch(pc));
         load_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         load_byte  = 8'($urandom);
         load_last  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         check("load_ready_run", {31'h0, load_ready}, 32'h0);
      end
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
      reload     = 1'b1;
      pc = pick_pc();
      sbq.push_back(expect_fetch(pc));
      @(posedge clk); #1;
      reload = 1'b0;
      model_wc  = 0;
      model_ovf = 1'b0;
      check("reload_core_rst", {31'h0, core_rst}, 32'h1);
      check("reload_word_count", {16'h0, word_count}, 32'h0);
      check("reload_overflow", {31'h0, overflow}, 32'h0);
      check("reload_load_ready", {31'h0, load_ready}, 32'h1);
   endtask

   initial begin
      bq_t b;
      wq_t none;
      wq_t pcs;
      for (int i = 0; i < SIZE; i++) model_wr[i] = 1'b0;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_core_rst", {31'h0, core_rst}, 32'h1);
      check("rst_load_ready", {31'h0, load_ready}, 32'h1);
      check("rst_word_count", {16'h0, word_count}, 32'h0);
      check("rst_overflow", {31'h0, overflow}, 32'h0);
      check("rst_instruction", {16'h0, instruction}, 32'h0);
      rst = 1'b1;

      // two-word image, then fetches at 0, 1 and far out of range
      b = {8'h20, 8'h81, 8'h20, 8'h82};
      send_image(b, 0, 1'b0);
      pcs = {16'h0000, 16'h0001, 16'hFFFF};
      run_phase(3, 1'b0, pcs);

      // odd image: trailing byte padded
      b = {8'h20, 8'h81, 8'h3C};
      send_image(b, 1, 1'b0);
      pcs = {16'h0001, 16'h0000, 16'(SIZE)};
      run_phase(4, 1'b0, pcs);

      // random images with gaps, reload noise while loading, load noise while running
      for (int it = 0; it < 8; it++) begin
         b = {};
         repeat ($urandom_range(1, 2*SIZE + 6)) b.push_back(8'($urandom));
         send_image(b, 2, 1'b1);
         run_phase(20, 1'b1, none);
      end

      // overflow: even and odd images longer than the memory
      b = {};
      repeat (2*SIZE + 4) b.push_back(8'($urandom));
      send_image(b, 0, 1'b0);
      pcs = {16'h0000, 16'(SIZE-1), 16'(SIZE), 16'h0003};
      run_phase(6, 1'b0, pcs);
      b = {};
      repeat (2*SIZE + 1) b.push_back(8'($urandom));
      send_image(b, 0, 1'b0);
      run_phase(6, 1'b0, none);

      // reset mid-word after one full word and a lone high byte
      b = {8'hDE, 8'hAD, 8'hBE};
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_byte  = b[i];
         load_last  = 1'b0;
         @(posedge clk); #1;
      end
      load_valid = 1'b0;
      model_mem[0] = 16'hDEAD;
      model_wr[0]  = 1'b1;
      check("midload_word_count", {16'h0, word_count}, 32'h1);
      #2 rst = 1'b0;
      #1;
      check("midrst_core_rst", {31'h0, core_rst}, 32'h1);
      check("midrst_load_ready", {31'h0, load_ready}, 32'h1);
      check("midrst_word_count", {16'h0, word_count}, 32'h0);
      check("midrst_overflow", {31'h0, overflow}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      model_wc  = 0;
      model_ovf = 1'b0;
      b = {8'h12, 8'h34, 8'h56, 8'h78};
      send_image(b, 1, 1'b0);
      pcs = {16'h0000, 16'h0001};
      run_phase(2, 1'b0, pcs);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sbq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
